// File: rtl/ts_cc_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// ts_cc_monitor_ctrl
//
// Continuity-counter monitor for MPEG-TS carried in IP/UDP payload bursts.
// Each data_in_en burst is one IP payload. The parser skips HDR_BYTES header
// bytes, then walks aligned TS_LEN-byte packets. It extracts PID and CC and
// checks them against a small software-configured PID table.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   data_in       stream byte, valid while data_in_en=1
//   data_in_en    burst framing (one burst = one IP payload)
//   cfg_we        single-cycle PID table write strobe
//   cfg_idx       table entry to write (indices >= NUM_PID are ignored)
//   cfg_pid       PID to monitor
//   cfg_valid     entry enable
//   err_clr       clears all error flags and counters
//   err_sel       selects the entry whose counter is shown on err_cnt
//   cc_err_flag   sticky per-entry CC error flag
//   err_cnt       saturating error count of entry err_sel (1-cycle latency)
//   sync_lost     one-cycle pulse when an expected sync byte is not 0x47
// ---------------------------------------------------------------------------
module ts_cc_monitor_ctrl #(
    parameter int NUM_PID   = 4,
    parameter int HDR_BYTES = 6,
    parameter int TS_LEN    = 188,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data_in,
    input  logic               data_in_en,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_idx,
    input  logic [12:0]        cfg_pid,
    input  logic               cfg_valid,
    input  logic               err_clr,
    input  logic [2:0]         err_sel,
    output logic [NUM_PID-1:0] cc_err_flag,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               sync_lost
);

    // The byte counter serves both the header skip and the packet body.
    localparam int MAX_LEN = (HDR_BYTES > TS_LEN) ? HDR_BYTES : TS_LEN;
    localparam int BCW     = $clog2(MAX_LEN + 1);

    localparam logic [BCW-1:0]   HDR_LAST = BCW'(HDR_BYTES);
    localparam logic [BCW-1:0]   PKT_LAST = BCW'(TS_LEN);
    localparam logic [BCW-1:0]   H3_POS   = BCW'(4);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE, SKIP, SYNC, H1, H2, H3, BODY, DROP
    } state_t;

    typedef struct packed {
        logic [12:0] pid;
        logic        valid;
        logic        seen;
        logic [3:0]  last_cc;
    } entry_t;

    state_t             state, state_nxt;
    logic [BCW-1:0]     byte_cnt;
    logic [BCW-1:0]     cnt_inc;
    logic [4:0]         pid_hi;
    logic [7:0]         pid_lo;
    logic [12:0]        pkt_pid;
    logic [3:0]         cc_in;
    logic               has_payload;
    logic               h3_fire;
    logic               taken;
    logic [NUM_PID-1:0] hit;
    logic [NUM_PID-1:0] err_vec;
    logic [NUM_PID-1:0] cfg_hit;
    logic [CNT_W-1:0]   sel_cnt;

    entry_t             tab       [NUM_PID];
    logic [CNT_W-1:0]   err_count [NUM_PID];

    assign cnt_inc     = byte_cnt + BCW'(1);
    assign pkt_pid     = {pid_hi, pid_lo};
    assign cc_in       = data_in[3:0];
    assign has_payload = data_in[4];
    assign h3_fire     = (state == H3) && data_in_en;

    // ---------------- Parser FSM ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        if (!data_in_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = (HDR_BYTES == 1) ? SYNC : SKIP;
                SKIP: if (cnt_inc == HDR_LAST) state_nxt = SYNC;
                SYNC: state_nxt = (data_in == 8'h47) ? H1 : DROP;
                H1:   state_nxt = H2;
                H2:   state_nxt = H3;
                H3:   state_nxt = BODY;
                BODY: if (cnt_inc == PKT_LAST) state_nxt = SYNC;
                DROP: state_nxt = DROP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bytes consumed so far in the header (IDLE/SKIP) or current packet (H3/BODY).
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (data_in_en) begin
            case (state)
                IDLE:       byte_cnt <= BCW'(1);
                SKIP, BODY: byte_cnt <= cnt_inc;
                H3:         byte_cnt <= H3_POS;
                default:    byte_cnt <= byte_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_hi    <= '0;
            pid_lo    <= '0;
            sync_lost <= 1'b0;
        end else begin
            if (data_in_en && state == H1) pid_hi <= data_in[4:0];
            if (data_in_en && state == H2) pid_lo <= data_in;
            sync_lost <= data_in_en && (state == SYNC) && (data_in != 8'h47);
        end
    end

    // ---------------- Lookup and CC check ----------------
    // Only the lowest-index matching entry is hit. A duplicate CC is always
    // accepted; with a payload, last_cc+1 (mod 16) is also accepted.
    always_comb begin
        hit     = '0;
        err_vec = '0;
        cfg_hit = '0;
        taken   = 1'b0;
        for (int i = 0; i < NUM_PID; i++) begin
            if (!taken && tab[i].valid && tab[i].pid == pkt_pid) begin
                hit[i] = h3_fire;
                taken  = 1'b1;
            end
            err_vec[i] = hit[i] && tab[i].seen && (cc_in != tab[i].last_cc) &&
                         (!has_payload || cc_in != (tab[i].last_cc + 4'd1));
            cfg_hit[i] = cfg_we && (cfg_idx == 3'(i));
        end
    end

    // A config write beats a same-cycle packet update. A new error beats a
    // same-cycle err_clr, so the counter restarts at 1.
    // NOTE: the table is explicitly reset; it is a handful of flops, not RAM,
    // and software relies on valid=0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_err_flag <= '0;
            for (int i = 0; i < NUM_PID; i++) begin
                tab[i]       <= '0;
                err_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PID; i++) begin
                if (cfg_hit[i]) begin
                    tab[i].pid     <= cfg_pid;
                    tab[i].valid   <= cfg_valid;
                    tab[i].seen    <= 1'b0;
                    cc_err_flag[i] <= 1'b0;
                    err_count[i]   <= '0;
                end else begin
                    if (hit[i] && has_payload) begin
                        tab[i].last_cc <= cc_in;
                        tab[i].seen    <= 1'b1;
                    end
                    if (err_vec[i]) begin
                        cc_err_flag[i] <= 1'b1;
                        if (err_clr)                       err_count[i] <= CNT_W'(1);
                        else if (err_count[i] != CNT_MAX)  err_count[i] <= err_count[i] + CNT_W'(1);
                    end else if (err_clr) begin
                        cc_err_flag[i] <= 1'b0;
                        err_count[i]   <= '0;
                    end
                end
            end
        end
    end

    // ---------------- Counter readout ----------------
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_PID; i++) begin
            if (err_sel == 3'(i)) sel_cnt = err_count[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt <= '0;
        else     err_cnt <= sel_cnt;
    end

endmodule

// File: tb/tb_ts_cc_monitor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ts_cc_monitor_ctrl
//
// Builds IP payload bursts out of header bytes and TS packets, drives them
// into ts_cc_monitor_ctrl and compares flags, counters and sync_lost pulses
// with a packet-level reference model of the CC rules. The DUT counter is
// narrowed to 4 bits so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_ts_cc_monitor_ctrl;

    localparam int NP   = 4;
    localparam int HDR  = 6;
    localparam int TSL  = 188;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_in;
    logic          data_in_en;
    logic          cfg_we;
    logic [2:0]    cfg_idx;
    logic [12:0]   cfg_pid;
    logic          cfg_valid;
    logic          err_clr;
    logic [2:0]    err_sel;
    logic [NP-1:0] cc_err_flag;
    logic [CW-1:0] err_cnt;
    logic          sync_lost;

    always #5 clk = ~clk;

    ts_cc_monitor_ctrl #(.NUM_PID(NP), .HDR_BYTES(HDR), .TS_LEN(TSL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_en(data_in_en),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pid(cfg_pid), .cfg_valid(cfg_valid),
        .err_clr(err_clr), .err_sel(err_sel),
        .cc_err_flag(cc_err_flag), .err_cnt(err_cnt), .sync_lost(sync_lost)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [12:0] m_pid   [NP];
    bit          m_valid [NP];
    bit          m_seen  [NP];
    logic [3:0]  m_last  [NP];
    bit          m_flag  [NP];
    int          m_cnt   [NP];
    int          exp_sl = 0;

    // Burst under construction and in-burst event hooks (byte indices)
    logic [7:0]  burst [$];
    int          clr_at = -1;
    int          cfg_at = -1;
    int          hk_idx;
    logic [12:0] hk_pid;
    logic        hk_valid;
    int          watch = 0;
    int          rise_idx;
    int          sl_count = 0;

    always @(negedge clk) if (sync_lost === 1'b1) sl_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- Reference model ----------------
    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin
            m_pid[i] = '0; m_valid[i] = 0; m_seen[i] = 0;
            m_last[i] = '0; m_flag[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < NP; i++) begin
            m_flag[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_cfg();
        if (hk_idx < NP) begin
            m_pid[hk_idx] = hk_pid; m_valid[hk_idx] = hk_valid;
            m_seen[hk_idx] = 0; m_flag[hk_idx] = 0; m_cnt[hk_idx] = 0;
        end
    endtask

    task automatic m_h3(input logic [12:0] pid, input logic [7:0] b);
        int hit;
        int cc;
        bit bad;
        hit = -1;
        cc  = int'(b[3:0]);
        for (int i = 0; i < NP; i++)
            if (hit < 0 && m_valid[i] && m_pid[i] == pid) hit = i;
        if (hit < 0) return;
        if (b[4]) begin
            bad = m_seen[hit] && cc != int'(m_last[hit]) && cc != (int'(m_last[hit]) + 1) % 16;
            m_last[hit] = b[3:0];
            m_seen[hit] = 1;
        end else begin
            bad = m_seen[hit] && cc != int'(m_last[hit]);
        end
        if (bad) begin
            m_flag[hit] = 1;
            if (m_cnt[hit] < CMAX) m_cnt[hit]++;
        end
    endtask

    // Walks the burst packet by packet; err_clr at a header byte precedes that
    // packet's check, a config write at the same byte follows it.
    task automatic model_burst();
        bit clr_done;
        bit cfg_done;
        int len;
        clr_done = (clr_at < 0);
        cfg_done = (cfg_at < 0);
        len      = burst.size();
        for (int s = HDR; s < len; s += TSL) begin
            if (burst[s] != 8'h47) begin exp_sl++; break; end
            if (s + 3 >= len) break;
            if (!clr_done && clr_at <= s + 3) begin m_clear(); clr_done = 1; end
            if (!cfg_done && cfg_at <  s + 3) begin m_cfg();   cfg_done = 1; end
            m_h3({burst[s+1][4:0], burst[s+2]}, burst[s+3]);
            if (!cfg_done && cfg_at == s + 3) begin m_cfg();   cfg_done = 1; end
        end
        if (!clr_done) m_clear();
        if (!cfg_done) m_cfg();
    endtask

    // ---------------- Stimulus helpers ----------------
    task automatic add_hdr();
        repeat (HDR) burst.push_back(8'($urandom));
    endtask

    task automatic add_pkt(input logic [12:0] pid, input logic [1:0] afc,
                           input logic [3:0] cc, input logic [7:0] sync);
        burst.push_back(sync);
        burst.push_back({3'b000, pid[12:8]});
        burst.push_back(pid[7:0]);
        burst.push_back({2'b00, afc, cc});
        repeat (TSL - 4) burst.push_back(8'($urandom));
    endtask

    task automatic cfg_write(input int idx, input logic [12:0] pid, input logic valid);
        hk_idx = idx; hk_pid = pid; hk_valid = valid;
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_pid = pid; cfg_valid = valid;
        @(negedge clk);
        cfg_we = 1'b0;
        m_cfg();
    endtask

    task automatic send_burst(input bit rst_end);
        rise_idx = -1;
        for (int i = 0; i < burst.size(); i++) begin
            @(negedge clk);
            if (rise_idx < 0 && cc_err_flag[watch] === 1'b1) rise_idx = i;
            data_in    = burst[i];
            data_in_en = 1'b1;
            err_clr    = (i == clr_at);
            cfg_we     = (i == cfg_at);
            cfg_idx    = 3'(hk_idx);
            cfg_pid    = hk_pid;
            cfg_valid  = hk_valid;
        end
        @(negedge clk);
        if (rise_idx < 0 && cc_err_flag[watch] === 1'b1) rise_idx = burst.size();
        err_clr = 1'b0;
        cfg_we  = 1'b0;
        model_burst();
        if (rst_end) begin
            rst = 1'b1; data_in = 8'h47;
            @(negedge clk);
            rst = 1'b0; data_in_en = 1'b0;
            m_reset();
        end else begin
            data_in_en = 1'b0;
        end
        repeat (3) @(negedge clk);
        clr_at = -1;
        cfg_at = -1;
    endtask

    task automatic get_cnt(input int idx, output int v);
        err_sel = 3'(idx);
        @(negedge clk);
        v = int'(err_cnt);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst = 1'b1; data_in = '0; data_in_en = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_pid = '0; cfg_valid = 1'b0; err_clr = 1'b0; err_sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_reset();
        total++; if (cc_err_flag !== '0) $display("FAIL reset_flag got %b expected 0", cc_err_flag); else passed++;
        total++; if (err_cnt !== '0) $display("FAIL reset_cnt got %0d expected 0", err_cnt); else passed++;
        total++; if (sync_lost !== 1'b0) $display("FAIL reset_sync_lost got %b expected 0", sync_lost); else passed++;
    endtask

    task automatic test_in_order();
        int v;
        cfg_write(0, 13'h1386, 1'b1);
        burst.delete(); add_hdr();
        for (int k = 3; k <= 5; k++) add_pkt(13'h1386, 2'b01, 4'(k), 8'h47);
        send_burst(0);
        for (int i = 0; i < NP; i++) begin
            get_cnt(i, v);
            total++; if (cc_err_flag[i] !== m_flag[i]) $display("FAIL in_order flag[%0d] got %b expected %b", i, cc_err_flag[i], m_flag[i]); else passed++;
            total++; if (v != m_cnt[i]) $display("FAIL in_order cnt[%0d] got %0d expected %0d", i, v, m_cnt[i]); else passed++;
        end
        total++; if (sl_count != 0) $display("FAIL in_order sync_lost pulses got %0d expected 0", sl_count); else passed++;
    endtask

    task automatic test_dup_jump();
        int v;
        logic [3:0] seq [4] = '{4'd3, 4'd4, 4'd4, 4'd6};
        cfg_write(0, 13'h1386, 1'b1);
        burst.delete(); add_hdr();
        for (int k = 0; k < 4; k++) add_pkt(13'h1386, 2'b01, seq[k], 8'h47);
        watch = 0;
        send_burst(0);
        total++; if (rise_idx != HDR + 3 * TSL + 4) $display("FAIL dup_jump flag timing got %0d expected %0d", rise_idx, HDR + 3 * TSL + 4); else passed++;
        get_cnt(0, v);
        total++; if (v != 1) $display("FAIL dup_jump cnt0 got %0d expected 1", v); else passed++;
        for (int i = 0; i < NP; i++) begin
            get_cnt(i, v);
            total++; if (cc_err_flag[i] !== m_flag[i]) $display("FAIL dup_jump flag[%0d] got %b expected %b", i, cc_err_flag[i], m_flag[i]); else passed++;
            total++; if (v != m_cnt[i]) $display("FAIL dup_jump cnt[%0d] got %0d expected %0d", i, v, m_cnt[i]); else passed++;
        end
    endtask

    task automatic test_sync_loss();
        int v;
        int sl0;
        cfg_write(0, 13'h1386, 1'b1);
        sl0 = sl_count;
        burst.delete(); add_hdr();
        add_pkt(13'h1386, 2'b01, 4'd7, 8'h47);
        add_pkt(13'h1386, 2'b01, 4'd8, 8'h00);
        add_pkt(13'h1386, 2'b01, 4'd2, 8'h47);
        send_burst(0);
        total++; if (sl_count - sl0 != 1) $display("FAIL sync_loss pulses got %0d expected 1", sl_count - sl0); else passed++;
        burst.delete(); add_hdr();
        add_pkt(13'h1386, 2'b01, 4'd8, 8'h47);
        add_pkt(13'h1386, 2'b01, 4'd9, 8'h47);
        send_burst(0);
        for (int i = 0; i < NP; i++) begin
            get_cnt(i, v);
            total++; if (cc_err_flag[i] !== m_flag[i]) $display("FAIL sync_loss flag[%0d] got %b expected %b", i, cc_err_flag[i], m_flag[i]); else passed++;
            total++; if (v != m_cnt[i]) $display("FAIL sync_loss cnt[%0d] got %0d expected %0d", i, v, m_cnt[i]); else passed++;
        end
        total++; if (sl_count != exp_sl) $display("FAIL sync_loss total pulses got %0d expected %0d", sl_count, exp_sl); else passed++;
    endtask

    task automatic test_dup_pid_saturate();
        int v;
        cfg_write(0, 13'h0100, 1'b1);
        cfg_write(1, 13'h0000, 1'b0);
        cfg_write(2, 13'h0100, 1'b1);
        cfg_write(3, 13'h0000, 1'b0);
        burst.delete(); add_hdr();
        for (int k = 0; k < 20; k++) add_pkt(13'h0100, 2'b11, 4'(2 * k), 8'h47);
        send_burst(0);
        get_cnt(0, v);
        total++; if (v != CMAX) $display("FAIL saturate cnt0 got %0d expected %0d", v, CMAX); else passed++;
        total++; if (cc_err_flag !== 4'b0001) $display("FAIL dup_pid flags got %b expected 0001", cc_err_flag); else passed++;
        get_cnt(5, v);
        total++; if (v != 0) $display("FAIL err_sel_oob got %0d expected 0", v); else passed++;
        for (int i = 0; i < NP; i++) begin
            get_cnt(i, v);
            total++; if (v != m_cnt[i]) $display("FAIL dup_pid cnt[%0d] got %0d expected %0d", i, v, m_cnt[i]); else passed++;
        end
    endtask

    task automatic test_collisions();
        int v;
        cfg_write(1, 13'h0200, 1'b1);
        burst.delete(); add_hdr();
        add_pkt(13'h0200, 2'b01, 4'd1, 8'h47);
        add_pkt(13'h0200, 2'b01, 4'd5, 8'h47);
        clr_at = HDR + TSL + 3;
        send_burst(0);
        total++; if (cc_err_flag !== 4'b0010) $display("FAIL clr_collide flags got %b expected 0010", cc_err_flag); else passed++;
        for (int i = 0; i < NP; i++) begin
            get_cnt(i, v);
            total++; if (v != ((i == 1) ? 1 : 0)) $display("FAIL clr_collide cnt[%0d] got %0d expected %0d", i, v, (i == 1) ? 1 : 0); else passed++;
        end
        // Config write lands on entry 1's header byte: the jump to 9 is dropped
        // and the next packet starts a fresh chain.
        burst.delete(); add_hdr();
        add_pkt(13'h0200, 2'b01, 4'd9, 8'h47);
        add_pkt(13'h0200, 2'b01, 4'd0, 8'h47);
        hk_idx = 1; hk_pid = 13'h0200; hk_valid = 1'b1;
        cfg_at = HDR + 3;
        send_burst(0);
        get_cnt(1, v);
        total++; if (cc_err_flag[1] !== 1'b0 || v != 0) $display("FAIL cfg_collide entry1 flag %b cnt %0d expected 0 0", cc_err_flag[1], v); else passed++;
        for (int i = 0; i < NP; i++) begin
            total++; if (cc_err_flag[i] !== m_flag[i]) $display("FAIL cfg_collide flag[%0d] got %b expected %b", i, cc_err_flag[i], m_flag[i]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int v;
        cfg_write(0, 13'h1386, 1'b1);
        burst.delete(); add_hdr();
        add_pkt(13'h1386, 2'b01, 4'd1, 8'h47);
        add_pkt(13'h1386, 2'b01, 4'd7, 8'h47);
        add_pkt(13'h1386, 2'b01, 4'd8, 8'h47);
        while (burst.size() > HDR + TSL + 100) void'(burst.pop_back());
        watch = 0;
        send_burst(1);
        total++; if (rise_idx != HDR + TSL + 4) $display("FAIL reset_mid pre-reset flag at %0d expected %0d", rise_idx, HDR + TSL + 4); else passed++;
        get_cnt(0, v);
        total++; if (cc_err_flag !== '0 || v != 0 || sync_lost !== 1'b0) $display("FAIL reset_mid outputs flag %b cnt %0d sl %b expected 0", cc_err_flag, v, sync_lost); else passed++;
        cfg_write(0, 13'h1386, 1'b1);
        burst.delete(); add_hdr();
        add_pkt(13'h1386, 2'b01, 4'd12, 8'h47);
        add_pkt(13'h1386, 2'b01, 4'd13, 8'h47);
        send_burst(0);
        for (int i = 0; i < NP; i++) begin
            get_cnt(i, v);
            total++; if (cc_err_flag[i] !== m_flag[i] || v != m_cnt[i]) $display("FAIL reset_mid entry[%0d] flag %b cnt %0d expected %b %0d", i, cc_err_flag[i], v, m_flag[i], m_cnt[i]); else passed++;
        end
    endtask

    task automatic test_random();
        int v;
        logic [12:0] pids [5] = '{13'h0100, 13'h0101, 13'h1386, 13'h1FFF, 13'h0055};
        int track [5] = '{0, 0, 0, 0, 0};
        for (int b = 0; b < 20; b++) begin
            for (int e = 0; e < NP; e++)
                if ($urandom_range(0, 3) == 0)
                    cfg_write(e, pids[$urandom_range(0, 3)], 1'($urandom_range(0, 4) != 0));
            burst.delete(); add_hdr();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                int p;
                int r;
                int cc;
                logic [1:0] afc;
                p   = $urandom_range(0, 4);
                r   = $urandom_range(0, 9);
                afc = 2'($urandom_range(0, 3));
                cc  = (r < 6) ? (track[p] + 1) % 16 : (r < 8) ? track[p] : int'($urandom_range(0, 15));
                if (afc[0]) track[p] = cc;
                add_pkt(pids[p], afc, 4'(cc), ($urandom_range(0, 11) == 0) ? 8'h46 : 8'h47);
            end
            if ($urandom_range(0, 3) == 0) begin
                int cut;
                cut = $urandom_range(HDR, burst.size() - 1);
                while (burst.size() > cut) void'(burst.pop_back());
            end
            if ($urandom_range(0, 3) == 0) clr_at = $urandom_range(0, burst.size() - 1);
            if ($urandom_range(0, 3) == 0) begin
                hk_idx = $urandom_range(0, 7); hk_pid = pids[$urandom_range(0, 3)]; hk_valid = 1'b1;
                cfg_at = $urandom_range(0, burst.size() - 1);
            end
            send_burst(0);
            for (int i = 0; i < NP; i++) begin
                get_cnt(i, v);
                total++; if (cc_err_flag[i] !== m_flag[i] || v != m_cnt[i]) $display("FAIL random b%0d entry[%0d] flag %b cnt %0d expected %b %0d", b, i, cc_err_flag[i], v, m_flag[i], m_cnt[i]); else passed++;
            end
            total++; if (sl_count != exp_sl) $display("FAIL random b%0d sync_lost pulses got %0d expected %0d", b, sl_count, exp_sl); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_dup_jump();
        test_sync_loss();
        test_dup_pid_saturate();
        test_collisions();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
